// File: rtl/control_unit.sv
// control_unit: hardwired Moore control FSM sequencing fetch/decode/execute for the 32-bit single-bus datapath.
// Optional feature: define MUL_DIV_EN to execute mul (01000) / div (01001); otherwise they decode as nop.
module control_unit #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
  output logic        Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout, CONin,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Read, Write,
  output logic [3:0]  ALUselect,
  output logic        run
);
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_RTYPE, C_IMM, C_LD, C_ST, C_BR, C_MFHI, C_MFLO, C_MULDIV, C_HALT
  } cls_t;

  localparam int unsigned CW = $clog2(MEM_WAIT_MAX + 1);

  state_t         state, state_nx;
  logic [4:0]     opcode;
  logic [CW-1:0]  wcnt;
  cls_t           cls, cls_ir;
  logic           waiting, timeout;
  logic           unused_ir;

  function automatic cls_t decode(input logic [4:0] op);
    cls_t c;
    c = C_NOP;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11: c = C_RTYPE;
`ifdef MUL_DIV_EN
      5'd8, 5'd9:                c = C_MULDIV;
`endif
      5'd12, 5'd13, 5'd14:       c = C_IMM;
      5'd16:                     c = C_LD;
      5'd17:                     c = C_ST;
      5'd18:                     c = C_BR;
      5'd20:                     c = C_MFHI;
      5'd21:                     c = C_MFLO;
      5'd27:                     c = C_HALT;
      default:                   c = C_NOP;
    endcase
    return c;
  endfunction

  assign unused_ir = ^ir[26:0];
  assign cls       = decode(opcode);
  // T2 decides the branch into execute from ir directly: the latch only updates on that same edge
  assign cls_ir    = decode(ir[31:27]);
  assign waiting   = (state == S_T1) || (state == S_T6 && cls == C_LD) ||
                     (state == S_T7 && cls == C_ST);
  assign timeout   = (wcnt >= CW'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= S_RST;
      opcode <= '0;
      wcnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_T2) opcode <= ir[31:27];
      wcnt <= (waiting && state_nx == state) ? wcnt + CW'(1) : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RST:  state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   if (mem_ready) state_nx = S_T2;
              else if (timeout) state_nx = S_HALT;
      S_T2:   case (cls_ir)
                C_NOP:   state_nx = S_T0;
                C_HALT:  state_nx = S_HALT;
                default: state_nx = S_T3;
              endcase
      S_T3:   state_nx = (cls == C_MFHI || cls == C_MFLO) ? S_T0 : S_T4;
      S_T4:   state_nx = S_T5;
      S_T5:   state_nx = (cls == C_RTYPE || cls == C_IMM) ? S_T0 : S_T6;
      S_T6:   if (cls == C_ST) state_nx = S_T7;
              else if (cls != C_LD) state_nx = S_T0;
              else if (mem_ready) state_nx = S_T7;
              else if (timeout) state_nx = S_HALT;
      S_T7:   if (cls != C_ST || mem_ready) state_nx = S_T0;
              else if (timeout) state_nx = S_HALT;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin} = '0;
    {Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout, CONin} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Read, Write}             = '0;
    ALUselect = '0;
    run       = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: {PCout, MARin, IncPC, Zin} = '1;
      S_T1: {Zlowout, PCin, Read, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: case (cls)
              C_RTYPE, C_IMM: {Grb, Rout, Yin} = '1;
              C_LD, C_ST:     {Grb, BAout, Yin} = '1;
              C_BR:           {Gra, Rout, CONin} = '1;
              C_MFHI:         {HIout, Gra, Rin} = '1;
              C_MFLO:         {LOout, Gra, Rin} = '1;
              C_MULDIV:       {Gra, Rout, Yin} = '1;
              default: ;
            endcase
      S_T4: case (cls)
              C_RTYPE:  begin {Grc, Rout, Zin} = '1; ALUselect = opcode[3:0]; end
              C_IMM:    begin
                          {Cout, Zin} = '1;
                          ALUselect = (opcode == 5'd13) ? 4'd2 : (opcode == 5'd14) ? 4'd3 : 4'd0;
                        end
              C_LD, C_ST: {Cout, Zin} = '1;
              C_BR:     {PCout, Yin} = '1;
              C_MULDIV: begin {Grb, Rout, Zin} = '1; ALUselect = opcode[3:0]; end
              default: ;
            endcase
      S_T5: case (cls)
              C_RTYPE, C_IMM: {Zlowout, Gra, Rin} = '1;
              C_LD, C_ST:     {Zlowout, MARin} = '1;
              C_BR:           {Cout, Zin} = '1;
              C_MULDIV:       {Zlowout, LOin} = '1;
              default: ;
            endcase
      S_T6: case (cls)
              C_LD:     {Read, MDRin} = '1;
              C_ST:     {Gra, Rout, MDRin} = '1;
              C_BR:     begin Zlowout = 1'b1; PCin = con_ff; end
              C_MULDIV: {Zhighout, HIin} = '1;
              default: ;
            endcase
      S_T7: case (cls)
              C_LD:    {MDRout, Gra, Rin} = '1;
              C_ST:    Write = 1'b1;
              default: ;
            endcase
      default: ;
    endcase
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore-style control FSM that sequences the 32-bit single-bus datapath through instruction fetch, decode and execute. It drives every register in/out strobe, the ALU select, and the memory read/write handshake. It consumes the IR contents and the branch condition flag. Register-file selection uses Gra/Grb/Grc/Rin/Rout/BAout, expanded by the separate select-and-encode block.

## Interface
Parameters:
- MEM_WAIT_MAX, 15: maximum cycles a memory state waits for mem_ready before the FSM enters HALT (timeout).

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- ir  in  32  IR contents; opcode = ir[31:27]
- con_ff  in  1  branch condition result (registered externally)
- mem_ready  in  1  memory access complete this cycle
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout, CONin  out  1 each  datapath strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/encode controls
- Read, Write  out  1 each  memory strobes
- ALUselect  out  4  0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shl, 6 ror, 7 rol, 8 mul, 9 div, 10 neg, 11 not
- run  out  1  high while not in RST or HALT

## Operation
- States: RST, T0–T7, HALT. Outputs are a pure decode of state plus the latched opcode. Any strobe not listed below is 0.
- RST: all outputs 0. Next state is T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Hold in T1 until mem_ready=1.
  - T2: MDRout, IRin. The opcode is latched from ir at the T2→T3 edge.
- Execute, by opcode class:
  - R-type (00000–01011, ALUselect = opcode[3:0]):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, ALUselect.
    - T5: Zlowout, Gra, Rin.
    - Then T0.
  - Immediate (01100 addi, 01101 andi, 01110 ori): as R-type, except T4 uses Cout instead of Grc/Rout. ALUselect is 0/2/3.
  - ld (10000):
    - T3: Grb, BAout, Yin.
    - T4: Cout, ALUselect=0, Zin.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin, wait for mem_ready.
    - T7: MDRout, Gra, Rin.
  - st (10001): T3–T5 as ld.
    - T6: Gra, Rout, MDRin.
    - T7: Write, wait for mem_ready.
  - br (10010):
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, ALUselect=0, Zin.
    - T6: Zlowout. PCin is asserted only if con_ff=1.
  - mfhi (10100): T3: HIout, Gra, Rin. mflo (10101): T3: LOout, Gra, Rin.
  - nop (11010): return to T0 after T2.
  - halt (11011): go to HALT after T2.
  - Undefined opcodes behave as nop.
- After the last T-state of each class, the next state is T0.
- HALT: all strobes 0, run=0. Only clear exits HALT.
- Memory timeout: a wait counter counts cycles spent in a wait state (T1, T6-ld, T7-st) and resets on leaving the state. If it reaches MEM_WAIT_MAX with mem_ready still 0, the next state is HALT.

## Timing
- clear sampled high at any edge, including mid-instruction or mid-wait: state=RST, opcode latch=0, wait counter=0. All outputs are 0 in the following cycle.
- Reset value of every output is 0, including run=0.
- Minimum instruction latency in cycles, from T0 through the final T-state, with mem_ready=1 immediately:
  - R-type/immediate: 6
  - ld/st: 8
  - br: 7
  - mf*: 4
  - nop: 3
- Each wait cycle in a memory state adds 1 cycle. mem_ready is ignored outside wait states.
- Strobes change only on clock edges. No strobe depends combinationally on inputs, except PCin in br-T6 (gated by con_ff).

## Configuration
- MUL_DIV_EN defined: opcodes 01000 (mul) and 01001 (div) execute:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, ALUselect=8/9, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then T0.
- MUL_DIV_EN undefined: 01000/01001 decode as nop, and ALUselect never outputs 8 or 9.

## Test plan
- clear for 2 cycles, then release → first cycle RST (all outputs 0, run=0), next cycle T0 with PCout=MARin=IncPC=Zin=1.
- add (ir=0x00000000 class), mem_ready tied 1 → T0..T5 in exactly 6 cycles; T4 has Grc=Rout=Zin=1 and ALUselect=0; T5 has Gra=Rin=Zlowout=1.
- ld with mem_ready low for 3 cycles in T6 → Read=MDRin=1 for 4 cycles; MDRout/Gra/Rin at T7; total 11 cycles.
- br with con_ff=0, then con_ff=1 → PCin=0 in T6, then PCin=1 in T6.
- mem_ready held 0 in T1 → HALT after MEM_WAIT_MAX=15 cycles with run=0; only clear recovers.
- mul with MUL_DIV_EN defined → LOin at T5, HIin at T6. Without the macro → T0 follows T2.
